cpu_trace_capture: RTL and testbench

- Passive observer on the single-cycle CPU's debug outputs. It is the consumer end of the CPU observation interface, where the test harness is the driver end.
- Captures one commit record per retired instruction into a small FIFO.
- Streams records out as 4 x 32-bit words over a valid/ready channel to a host/logger.
- Keeps retire and drop statistics for bring-up and regression.

---
 rtl/cpu_trace_capture_if.sv | 37 +++
 rtl/cpu_trace_capture.sv | 130 +++++++++++++
 tb/tb_cpu_trace_capture.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_capture_if
// Brief    : CPU observation signals plus the outgoing trace word stream.
//            master = test harness / CPU side, slave = trace capture block.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_trace_capture_if;
  // CPU debug outputs observed each cycle
  logic [31:0] PC;
  logic [31:0] instruction;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWre;
  logic        DataMemRW;
  logic        zero;
  logic        PCSrc;
  logic        PCWre;
  // Trace word stream towards the host/logger
  logic        tr_valid;
  logic [31:0] tr_data;
  logic        tr_last;
  logic        tr_ready;

  modport master (
    output PC, instruction, WriteReg, WriteData, RegWre, DataMemRW, zero,
           PCSrc, PCWre, tr_ready,
    input  tr_valid, tr_data, tr_last
  );

  modport slave (
    input  PC, instruction, WriteReg, WriteData, RegWre, DataMemRW, zero,
           PCSrc, PCWre, tr_ready,
    output tr_valid, tr_data, tr_last
  );
endinterface
`default_nettype wire

// File: rtl/cpu_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_capture
// Brief    : Passive commit-trace capture. One 4-word record per qualified
//            retire goes into a small FIFO and is streamed out word by word.
//            Keeps retire and drop statistics.
// Options  : TRACE_WB_FILTER_EN - only store retires that write a register
//            or memory (seq/retire_cnt still count every retire).
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_capture #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                cap_en,
  cpu_trace_capture_if.slave       bus,
  output logic [ADDR_W:0]          fifo_level,
  output logic [31:0]              retire_cnt,
  output logic [15:0]              drop_cnt
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

  // Record storage: {w0, w1, w2, w3} with w0 in the top 32 bits
  logic [127:0]      r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_level;
  logic [1:0]        r_idx;
  logic [7:0]        r_seq;
  logic [31:0]       r_retire;
  logic [15:0]       r_drop;

  logic              w_qual;
  logic              w_want;
  logic              w_valid;
  logic              w_hs;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [127:0]      w_rec;
  logic [127:0]      w_head;

  assign w_qual = cap_en & bus.PCWre;

`ifdef TRACE_WB_FILTER_EN
  // Skip retires with no architectural side effect
  assign w_want = w_qual & (bus.RegWre | bus.DataMemRW);
`else
  assign w_want = w_qual;
`endif

  assign w_valid = (r_level != '0);
  assign w_hs    = w_valid & bus.tr_ready;
  assign w_pop   = w_hs & (r_idx == 2'd3);
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_push  = w_want & ((r_level < c_depth) | w_pop);
  assign w_drop  = w_want & ~w_push;

  assign w_rec = {bus.PC, bus.instruction, bus.WriteData,
                  r_seq, 3'b000, bus.WriteReg, bus.RegWre, bus.DataMemRW,
                  bus.zero, bus.PCSrc, 12'h000};

  assign w_head = r_mem[r_rdPtr];

  // Present the current word of the head record
  always_comb begin
    bus.tr_data = w_head[127:96];
    case (r_idx)
      2'd0:    bus.tr_data = w_head[127:96];
      2'd1:    bus.tr_data = w_head[95:64];
      2'd2:    bus.tr_data = w_head[63:32];
      default: bus.tr_data = w_head[31:0];
    endcase
  end

  assign bus.tr_valid = w_valid;
  assign bus.tr_last  = w_valid & (r_idx == 2'd3);
  assign fifo_level   = r_level;
  assign retire_cnt   = r_retire;
  assign drop_cnt     = r_drop;

  // Record RAM write; contents need no reset since pointers guard them
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wrPtr] <= w_rec;
    end
  end

  // FIFO pointers, occupancy and output word index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_idx   <= 2'd0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_hs)   r_idx   <= r_idx + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_one;
        2'b01:   r_level <= r_level - c_one;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sequence number and statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq    <= 8'd0;
      r_retire <= 32'd0;
      r_drop   <= 16'd0;
    end else begin
      if (w_qual) begin
        r_seq    <= r_seq + 8'd1;
        r_retire <= r_retire + 32'd1;
      end
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_capture
// Brief    : Scoreboard bench for cpu_trace_capture. The driver issues
//            retires and pushes expected words; a negedge monitor compares
//            the stream and statistics against the reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_capture;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              capEn;
  logic [ADDR_W:0]   fifoLevel;
  logic [31:0]       retireCnt;
  logic [15:0]       dropCnt;

  cpu_trace_capture_if ifc ();

  cpu_trace_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (capEn),
    .bus        (ifc),
    .fifo_level (fifoLevel),
    .retire_cnt (retireCnt),
    .drop_cnt   (dropCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       expQ[$];
  int          mLevel;
  int          mIdx;
  logic [7:0]  mSeq;
  logic [31:0] mRetire;
  logic [15:0] mDrop;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    mLevel  = 0;
    mIdx    = 0;
    mSeq    = 8'd0;
    mRetire = 32'd0;
    mDrop   = 16'd0;
  endtask

  // Reference behaviour for one rising edge, from the inputs held at the edge
  task automatic modelStep();
    logic qual, want, hs, pop, push;
    logic [31:0] w3;
    if (reset) return;
    qual = capEn && ifc.PCWre;
`ifdef TRACE_WB_FILTER_EN
    want = qual && (ifc.RegWre || ifc.DataMemRW);
`else
    want = qual;
`endif
    hs   = (mLevel != 0) && ifc.tr_ready;
    pop  = hs && (mIdx == 3);
    push = want && ((mLevel < DEPTH) || pop);
    if (push) begin
      w3 = {mSeq, 3'b000, ifc.WriteReg, ifc.RegWre, ifc.DataMemRW,
            ifc.zero, ifc.PCSrc, 12'h000};
      expQ.push_back('{ifc.PC, 1'b0});
      expQ.push_back('{ifc.instruction, 1'b0});
      expQ.push_back('{ifc.WriteData, 1'b0});
      expQ.push_back('{w3, 1'b1});
    end
    if (want && !push && mDrop != 16'hFFFF) mDrop++;
    if (qual) begin
      mSeq++;
      mRetire++;
    end
    if (hs) mIdx = (mIdx + 1) % 4;
    mLevel = mLevel + (push ? 1 : 0) - (pop ? 1 : 0);
  endtask

  // One cycle of stimulus, set just after an edge and modelled at the next
  task automatic step(input logic en, input logic wre, input logic rdy,
                      input logic [31:0] pc, input logic rw, input logic mw);
    capEn             = en;
    ifc.PCWre         = wre;
    ifc.tr_ready      = rdy;
    ifc.PC            = pc;
    ifc.instruction   = $urandom;
    ifc.WriteData     = $urandom;
    ifc.WriteReg      = 5'($urandom);
    ifc.RegWre        = rw;
    ifc.DataMemRW     = mw;
    ifc.zero          = 1'($urandom);
    ifc.PCSrc         = 1'($urandom);
    @(posedge clk);
    modelStep();
    #2;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rdy, $urandom, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearModel();
    idle(2, 1'b0);
    reset = 1'b0;
  endtask

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    chk("tr_valid", {31'd0, ifc.tr_valid}, {31'd0, (mLevel != 0)});
    chk("fifo_level", {28'd0, fifoLevel}, 32'(mLevel));
    chk("retire_cnt", retireCnt, mRetire);
    chk("drop_cnt", {16'd0, dropCnt}, {16'd0, mDrop});
    if (mLevel != 0 && expQ.size() > 0) begin
      chk("tr_data", ifc.tr_data, expQ[0].data);
      chk("tr_last", {31'd0, ifc.tr_last}, {31'd0, expQ[0].last});
      if (ifc.tr_ready) void'(expQ.pop_front());
    end
  end

  logic [31:0] savedRetire;

  initial begin
    reset = 1'b1;
    capEn = 1'b0;
    ifc.PC = '0; ifc.instruction = '0; ifc.WriteReg = '0; ifc.WriteData = '0;
    ifc.RegWre = 1'b0; ifc.DataMemRW = 1'b0; ifc.zero = 1'b0; ifc.PCSrc = 1'b0;
    ifc.PCWre = 1'b0; ifc.tr_ready = 1'b0;
    clearModel();
    idle(3, 1'b0);
    reset = 1'b0;

    // Three back-to-back records streamed with ready held high
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    idle(14, 1'b1);
    chk("t1_level", {28'd0, fifoLevel}, 32'd0);
    chk("t1_retire", retireCnt, 32'd3);

    // Overfill with ready low, then stall mid-record and drain
    doReset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    chk("t2_level", {28'd0, fifoLevel}, 32'd8);
    chk("t2_drop", {16'd0, dropCnt}, 32'd2);
    chk("t2_retire", retireCnt, 32'd10);
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(40, 1'b1);

    // Full FIFO while retiring every cycle during drain
    doReset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    chk("t4_drop", {16'd0, dropCnt}, 32'd9);
    chk("t4_level", {28'd0, fifoLevel}, 32'd8);
    idle(40, 1'b1);

    // Halted CPU and disabled capture leave state untouched
    savedRetire = retireCnt;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, $urandom, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 1'b1);
    chk("t5_retire_hold", retireCnt, savedRetire);
    chk("t5_level", {28'd0, fifoLevel}, 32'd0);

    // Asynchronous reset in the middle of a record
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    clearModel();
    #1;
    chk("t5_async_valid", {31'd0, ifc.tr_valid}, 32'd0);
    chk("t5_async_level", {28'd0, fifoLevel}, 32'd0);
    idle(2, 1'b1);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    idle(6, 1'b1);

    // add, beq, sw, lw
    doReset();
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, $urandom, 1'b1, 1'b0);
    idle(20, 1'b1);
    chk("t6_retire", retireCnt, 32'd4);
    chk("t6_drop", {16'd0, dropCnt}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9,
           $urandom_range(0, 9) < 6, $urandom,
           1'($urandom), 1'($urandom));
    end
    idle(60, 1'b1);
    chk("final_level", {28'd0, fifoLevel}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
